// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU-side bus master.
// State encoding, bus width and the default abort limit live here.
package bus_pkg;

   localparam int BUS_W       = 32;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } state_t;

   typedef struct packed {
      logic             req;
      logic             rw;
      logic             done;
      logic             err;
      logic             busy;
      logic [BUS_W-1:0] addr;
      logic [BUS_W-1:0] wdata;
      logic [BUS_W-1:0] rdata;
   } regs_t;

   localparam regs_t REGS_RST = '0;

endpackage

// File: rtl/bus_master_watchdog.sv
// WAIT-cycle counter; expired flags the cycle that would reach TIMEOUT.
// Only built when BUS_TIMEOUT_EN is defined.
module bus_watchdog
   import bus_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic clrn,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/bus_master.sv
// Single-outstanding CPU-to-bus master with IDLE/WAIT/DONE sequencing.
// Optional abort on slow slaves: define BUS_TIMEOUT_EN.
module bus_master
   import bus_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [BUS_W-1:0] cpu_addr,
   input  logic [BUS_W-1:0] cpu_wdata,
   output logic             cpu_busy,
   output logic             cpu_done,
   output logic [BUS_W-1:0] cpu_rdata,
   output logic             cpu_err,
   output logic             request,
   output logic [BUS_W-1:0] address,
   output logic             r_w,
   inout  wire  [BUS_W-1:0] data,
   input  logic             ready
);

   state_t st, st_nx;
   regs_t  r, r_nx;
   logic   expired;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         st <= IDLE;
         r  <= REGS_RST;
      end else begin
         st <= st_nx;
         r  <= r_nx;
      end
   end

   always_comb begin
      st_nx  = st;
      r_nx   = r;
      r_nx.done = 1'b0;
      r_nx.err  = 1'b0;
      unique case (st)
         IDLE: begin
            if (cpu_req) begin
               st_nx      = WAIT;
               r_nx.req   = 1'b1;
               r_nx.addr  = cpu_addr;
               r_nx.rw    = cpu_we;
               r_nx.wdata = cpu_wdata;
            end
         end
         WAIT: begin
            // A real ready wins over an abort in the same cycle.
            if (ready) begin
               st_nx     = DONE;
               r_nx.req  = 1'b0;
               r_nx.addr = '0;
               r_nx.rw   = 1'b0;
               r_nx.done = 1'b1;
               if (!r.rw) r_nx.rdata = data;
            end else if (expired) begin
               st_nx     = DONE;
               r_nx.req  = 1'b0;
               r_nx.addr = '0;
               r_nx.rw   = 1'b0;
               r_nx.done = 1'b1;
               r_nx.err  = 1'b1;
            end
         end
         DONE: st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
      r_nx.busy = (st_nx != IDLE);
   end

`ifdef BUS_TIMEOUT_EN
   bus_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_wd (
      .clk    (clk),
      .clrn   (clrn),
      .enable ((st == WAIT) && !ready),
      .clear  (st != WAIT),
      .expired(expired)
   );
`else
   assign expired = 1'b0;
`endif

   assign data      = (st == WAIT && r.rw) ? r.wdata : 'z;
   assign request   = r.req;
   assign address   = r.addr;
   assign r_w       = r.rw;
   assign cpu_busy  = r.busy;
   assign cpu_done  = r.done;
   assign cpu_err   = r.err;
   assign cpu_rdata = r.rdata;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master against a four-cycle slave (0..0x1FFF).
// Completions are checked against a queue of expected results.
module tb_bus_master;

   logic        clk;
   logic        clrn;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_busy;
   logic        cpu_done;
   logic [31:0] cpu_rdata;
   logic        cpu_err;
   logic        request;
   logic [31:0] address;
   logic        r_w;
   tri1  [31:0] data;
   tri0         ready;

   localparam logic [31:0] REL = 32'hFFFF_FFFF;

   bus_master #(
      .TIMEOUT(16)
   ) dut (
      .clk      (clk),
      .clrn     (clrn),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_busy (cpu_busy),
      .cpu_done (cpu_done),
      .cpu_rdata(cpu_rdata),
      .cpu_err  (cpu_err),
      .request  (request),
      .address  (address),
      .r_w      (r_w),
      .data     (data),
      .ready    (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // slave: ready on the 4th sampled request cycle, mapped range only
   logic [31:0] mem [0:8191];
   int          scnt;
   logic        smap;
   logic        srdy;

   assign smap  = (address < 32'h2000);
   assign srdy  = request && smap && (scnt == 4);
   assign ready = srdy;
   assign data  = (srdy && !r_w) ? mem[address[12:0]] : 'z;

   always @(posedge clk) begin
      scnt <= request ? scnt + 1 : 0;
      if (srdy && r_w) mem[address[12:0]] <= data;
   end

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t        sbq[$];
   exp_t        e;
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] last_rd  = 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (cpu_done) begin
         if (sbq.size() == 0) begin
            chk("spurious_done", {31'd0, cpu_done}, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("sb_rdata", cpu_rdata, e.rd);
            chk("sb_err", {31'd0, cpu_err}, {31'd0, e.err});
         end
      end
   end

   task automatic run_txn(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input int lat,
                          input bit poke);
      int   n;
      logic seen;
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      sbq.push_back({exp_rd, exp_err});
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      chk("acc_req", {31'd0, request}, 32'd1);
      chk("acc_busy", {31'd0, cpu_busy}, 32'd1);
      chk("acc_rw", {31'd0, r_w}, {31'd0, we});
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 400) begin
         chk("wait_addr", address, addr);
         chk("wait_req", {31'd0, request}, 32'd1);
         if (we) chk("wr_data", data, wd);
         else if (n < 4) chk("rd_z", data, REL);
         if (poke && n == 2) begin
            cpu_req  = 1'b1;
            cpu_addr = 32'h0000_1234;
         end else if (poke && n == 3) begin
            cpu_req = 1'b0;
         end
         @(posedge clk);
         #1;
         n++;
         seen = cpu_done;
      end
      chk("latency", n, lat);
      chk("done_req", {31'd0, request}, 32'd0);
      chk("done_addr", address, 32'd0);
      chk("done_rw", {31'd0, r_w}, 32'd0);
      chk("done_data", data, REL);
      @(posedge clk);
      #1;
      chk("post_done", {31'd0, cpu_done}, 32'd0);
      chk("post_busy", {31'd0, cpu_busy}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout observed=hang expected=finish");
      $fatal(1, "time limit");
   end

   initial begin
      clrn      = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", {31'd0, request}, 32'd0);
      chk("rst_addr", address, 32'd0);
      chk("rst_busy", {31'd0, cpu_busy}, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_err", {31'd0, cpu_err}, 32'd0);
      chk("rst_data", data, REL);
      @(negedge clk);
      clrn = 1'b1;

      run_txn(1'b1, 32'h10, 32'hCAFE_BABE, last_rd, 1'b0, 5, 1'b0);
      run_txn(1'b0, 32'h10, 32'h0, 32'hCAFE_BABE, 1'b0, 5, 1'b0);
      last_rd = 32'hCAFE_BABE;
      run_txn(1'b1, 32'h11, 32'h1234_5678, last_rd, 1'b0, 5, 1'b1);

      // back-to-back reads with cpu_req held high
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h11;
      sbq.push_back({32'h1234_5678, 1'b0});
      sbq.push_back({32'hCAFE_BABE, 1'b0});
      @(posedge clk);
      #1;
      cpu_addr = 32'h10;
      for (int k = 1; k <= 13; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("b2b_req%0d", k), {31'd0, request},
             {31'd0, (k < 5) || (k >= 7 && k < 12)});
         chk($sformatf("b2b_busy%0d", k), {31'd0, cpu_busy},
             {31'd0, (k < 6) || (k >= 7 && k < 13)});
         chk($sformatf("b2b_done%0d", k), {31'd0, cpu_done},
             {31'd0, (k == 5) || (k == 12)});
         if (k == 7) begin
            chk("b2b_addr2", address, 32'h10);
            cpu_req = 1'b0;
         end
      end
      last_rd = 32'hCAFE_BABE;

`ifdef BUS_TIMEOUT_EN
      run_txn(1'b0, 32'h0010_0000, 32'h0, last_rd, 1'b1, 16, 1'b0);
`endif

      // reset in the middle of a write: abandoned, nothing stored
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 32'h10;
      cpu_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_data", data, 32'hDEAD_BEEF);
      clrn = 1'b0;
      #1;
      chk("arst_req", {31'd0, request}, 32'd0);
      chk("arst_addr", address, 32'd0);
      chk("arst_rw", {31'd0, r_w}, 32'd0);
      chk("arst_busy", {31'd0, cpu_busy}, 32'd0);
      chk("arst_rdata", cpu_rdata, 32'd0);
      chk("arst_data", data, REL);
      last_rd = 32'h0;
      @(negedge clk);
      @(negedge clk);
      clrn = 1'b1;
      run_txn(1'b0, 32'h10, 32'h0, 32'hCAFE_BABE, 1'b0, 5, 1'b0);

      repeat (3) @(posedge clk);
      #2;
      chk("sb_empty", sbq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
